// File: rtl/iomem_quad_encoder_pkg.sv
// Register map, field positions and mode encodings shared by the encoder bank and its channels.
// Pure definitions: no logic, no latency, no flow control.
package iomem_quad_encoder_pkg;

   typedef enum logic [1:0] {
      REG_COUNT    = 2'd0,
      REG_VELOCITY = 2'd1,
      REG_STATUS   = 2'd2,
      REG_CTRL     = 2'd3
   } enc_reg_e;

   typedef enum logic [1:0] {
      MODE_X4  = 2'b00,
      MODE_X2  = 2'b01,
      MODE_X1  = 2'b10,
      MODE_RSV = 2'b11
   } enc_mode_e;

   localparam int STAT_W    = 3;
   localparam int STAT_OVF  = 0;
   localparam int STAT_UNF  = 1;
   localparam int STAT_QERR = 2;

   localparam int CTRL_W       = 5;
   localparam int CTRL_EN      = 0;
   localparam int CTRL_INV     = 1;
   localparam int CTRL_MODE_LO = 2;
   localparam int CTRL_IRQEN   = 4;
   localparam logic [CTRL_W-1:0] CTRL_RST = 5'h01;

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = {8{strb[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/quad_encoder_channel.sv
// One encoder channel: sync + glitch filter, x4/x2/x1 decode, wrapping counter, velocity, STATUS/CTRL.
// Pin edge reaches COUNT FILT_LEN+3 cycles later; register writes take effect on the bus accept edge.
module quad_encoder_channel
   import iomem_quad_encoder_pkg::*;
#(
   parameter int CNT_W    = 32,
   parameter int FILT_LEN = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enc_a,
   input  logic        enc_b,
   input  logic        vel_tick,
   input  logic        wr_en,
   input  enc_reg_e    reg_sel,
   input  logic [3:0]  wr_strb,
   input  logic [31:0] wr_dat,
   output logic [31:0] rd_dat,
   output logic        irq_req
);

   logic [1:0]            sync1_q, sync1_d;
   logic [1:0]            sync2_q, sync2_d;
   logic [1:0]            filt_q, filt_d;
   logic [1:0][3:0]       fcnt_q, fcnt_d;
   logic [1:0]            prev_q, prev_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [CNT_W-1:0]      snap_q, snap_d;
   logic [CNT_W-1:0]      vel_q, vel_d;
   logic [STAT_W-1:0]     status_q, status_d;
   logic [CTRL_W-1:0]     ctrl_q, ctrl_d;

   logic                  a_chg, b_chg, fwd, en;
   logic                  cnt_evt, inc, dec;
   logic                  ovf_evt, unf_evt, qerr_evt;
   logic                  wr_cnt, wr_stat, wr_ctrl;
   logic [31:0]           strb_m;
   logic [CNT_W-1:0]      cmask, preset;
   logic [STAT_W-1:0]     stat_set, stat_clr;
   enc_mode_e             mode;
   logic                  unused_bits;

   assign unused_bits = ^{wr_dat, strb_m};

   always_comb begin
      sync1_d = {enc_a, enc_b};
      sync2_d = sync1_q;
      filt_d  = filt_q;
      fcnt_d  = fcnt_q;
      // A pin level is only accepted after FILT_LEN agreeing samples that differ from it.
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] == filt_q[i]) begin
            fcnt_d[i] = '0;
         end else if (fcnt_q[i] == 4'(FILT_LEN-1)) begin
            filt_d[i] = sync2_q[i];
            fcnt_d[i] = '0;
         end else begin
            fcnt_d[i] = fcnt_q[i] + 4'd1;
         end
      end
      prev_d = filt_q;
   end

   always_comb begin
      en    = ctrl_q[CTRL_EN];
      mode  = enc_mode_e'(ctrl_q[CTRL_MODE_LO +: 2]);
      a_chg = prev_q[1] ^ filt_q[1];
      b_chg = prev_q[0] ^ filt_q[0];
      // Along 00->10->11->01 an A edge lands on A!=B and a B edge lands on A==B.
      fwd   = (a_chg ? (filt_q[1] ^ filt_q[0]) : ~(filt_q[1] ^ filt_q[0])) ^ ctrl_q[CTRL_INV];
      qerr_evt = en & a_chg & b_chg;
      case (mode)
         MODE_X2: cnt_evt = en & a_chg & ~b_chg;
         MODE_X1: cnt_evt = en & a_chg & ~b_chg & filt_q[1];
         default: cnt_evt = en & (a_chg ^ b_chg);
      endcase
      inc = cnt_evt & fwd;
      dec = cnt_evt & ~fwd;
   end

   always_comb begin
      wr_cnt  = wr_en && (reg_sel == REG_COUNT);
      wr_stat = wr_en && (reg_sel == REG_STATUS);
      wr_ctrl = wr_en && (reg_sel == REG_CTRL);
      strb_m  = strb_mask(wr_strb);
      cmask   = strb_m[CNT_W-1:0];
      preset  = (count_q & ~cmask) | (wr_dat[CNT_W-1:0] & cmask);

      count_d = count_q;
      snap_d  = snap_q;
      vel_d   = vel_q;
      if (vel_tick) begin
         vel_d  = count_q - snap_q;
         snap_d = count_q;
      end
      // A preset overrides a same-cycle count and re-bases the velocity window.
      if (wr_cnt) begin
         count_d = preset;
         snap_d  = preset;
      end else if (inc) begin
         count_d = count_q + CNT_W'(1);
      end else if (dec) begin
         count_d = count_q - CNT_W'(1);
      end

      ovf_evt  = inc & ~wr_cnt & (&count_q);
      unf_evt  = dec & ~wr_cnt & (count_q == '0);
      stat_set = '0;
      stat_set[STAT_OVF]  = ovf_evt;
      stat_set[STAT_UNF]  = unf_evt;
      stat_set[STAT_QERR] = qerr_evt;
      stat_clr = (wr_stat && wr_strb[0]) ? wr_dat[STAT_W-1:0] : '0;
      status_d = (status_q & ~stat_clr) | stat_set;

      ctrl_d = (wr_ctrl && wr_strb[0]) ? wr_dat[CTRL_W-1:0] : ctrl_q;
   end

   always_comb begin
      rd_dat = '0;
      case (reg_sel)
         REG_COUNT:    rd_dat = 32'(count_q);
         REG_VELOCITY: rd_dat = 32'(vel_q);
         REG_STATUS:   rd_dat = 32'(status_q);
         REG_CTRL:     rd_dat = 32'(ctrl_q);
         default:      rd_dat = '0;
      endcase
   end

   assign irq_req = (|status_q) & ctrl_q[CTRL_IRQEN];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         filt_q   <= '0;
         fcnt_q   <= '0;
         prev_q   <= '0;
         count_q  <= '0;
         snap_q   <= '0;
         vel_q    <= '0;
         status_q <= '0;
         ctrl_q   <= CTRL_RST;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         filt_q   <= filt_d;
         fcnt_q   <= fcnt_d;
         prev_q   <= prev_d;
         count_q  <= count_d;
         snap_q   <= snap_d;
         vel_q    <= vel_d;
         status_q <= status_d;
         ctrl_q   <= ctrl_d;
      end
   end

endmodule

// File: rtl/iomem_quad_encoder_bank.sv
// PicoSoC iomem front end for NUM_CH quadrature encoder channels: bus decode, readback, prescaler, irq.
// Matched requests are acked one cycle later (one access per two cycles); unmatched ones are never acked.
module iomem_quad_encoder_bank
   import iomem_quad_encoder_pkg::*;
#(
   parameter int          NUM_CH     = 2,
   parameter int          CNT_W      = 32,
   parameter int          FILT_LEN   = 3,
   parameter int          VEL_PERIOD = 16000,
   parameter logic [23:0] BASE_PAGE  = 24'h030004
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              iomem_valid,
   output logic              iomem_ready,
   input  logic [3:0]        iomem_wstrb,
   input  logic [31:0]       iomem_addr,
   input  logic [31:0]       iomem_wdata,
   output logic [31:0]       iomem_rdata,
   input  logic [NUM_CH-1:0] enc_a,
   input  logic [NUM_CH-1:0] enc_b,
   output logic              irq
);

   localparam int PW = $clog2(VEL_PERIOD);

   logic [PW-1:0]     presc_q, presc_d;
   logic              ready_q, ready_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              irq_q, irq_d;

   logic              req, vel_tick;
   logic [3:0]        ch_sel;
   enc_reg_e          reg_sel;
   logic [31:0]       sel_rd;
   logic [31:0]       ch_rd [NUM_CH];
   logic [NUM_CH-1:0] ch_irq;
   logic [NUM_CH-1:0] ch_wr;
   logic              unused_addr;

   assign unused_addr = ^iomem_addr[1:0];

   always_comb begin
      req     = iomem_valid && !ready_q && (iomem_addr[31:8] == BASE_PAGE);
      ch_sel  = iomem_addr[7:4];
      reg_sel = enc_reg_e'(iomem_addr[3:2]);

      vel_tick = (presc_q == PW'(VEL_PERIOD-1));
      presc_d  = vel_tick ? '0 : presc_q + PW'(1);

      // Channels beyond NUM_CH match no index: reads return 0 and writes go nowhere.
      sel_rd = '0;
      ch_wr  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel == 4'(i)) begin
            sel_rd   = ch_rd[i];
            ch_wr[i] = req && (|iomem_wstrb);
         end
      end

      ready_d = req;
      rdata_d = req ? sel_rd : rdata_q;
      irq_d   = |ch_irq;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      quad_encoder_channel #(
         .CNT_W    (CNT_W),
         .FILT_LEN (FILT_LEN)
      ) u_ch (
         .clk      (clk),
         .resetn   (resetn),
         .enc_a    (enc_a[g]),
         .enc_b    (enc_b[g]),
         .vel_tick (vel_tick),
         .wr_en    (ch_wr[g]),
         .reg_sel  (reg_sel),
         .wr_strb  (iomem_wstrb),
         .wr_dat   (iomem_wdata),
         .rd_dat   (ch_rd[g]),
         .irq_req  (ch_irq[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         presc_q <= '0;
         ready_q <= 1'b0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         presc_q <= presc_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_quad_encoder_bank.sv
// Directed bench for iomem_quad_encoder_bank: reset state, decode modes, status/irq, filter timing,
// velocity windows, byte-strobed presets and out-of-range channels.
module tb_iomem_quad_encoder_bank;

   localparam int          NUM_CH     = 2;
   localparam int          CNT_W      = 32;
   localparam int          FILT_LEN   = 3;
   localparam int          VEL_PERIOD = 100;
   localparam logic [23:0] BASE_PAGE  = 24'h030004;

   localparam logic [1:0] R_CNT  = 2'd0;
   localparam logic [1:0] R_VEL  = 2'd1;
   localparam logic [1:0] R_STAT = 2'd2;
   localparam logic [1:0] R_CTRL = 2'd3;

   logic              clk = 1'b0;
   logic              resetn;
   logic              iomem_valid;
   logic              iomem_ready;
   logic [3:0]        iomem_wstrb;
   logic [31:0]       iomem_addr;
   logic [31:0]       iomem_wdata;
   logic [31:0]       iomem_rdata;
   logic [NUM_CH-1:0] enc_a;
   logic [NUM_CH-1:0] enc_b;
   logic              irq;

   int          n_cmp = 0;
   int          n_mis = 0;
   int          cyc = 0;
   int          rst_cyc = 0;
   logic [31:0] rv;
   logic [1:0]  ab;
   logic        seen;

   iomem_quad_encoder_bank #(
      .NUM_CH     (NUM_CH),
      .CNT_W      (CNT_W),
      .FILT_LEN   (FILT_LEN),
      .VEL_PERIOD (VEL_PERIOD),
      .BASE_PAGE  (BASE_PAGE)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .enc_a       (enc_a),
      .enc_b       (enc_b),
      .irq         (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_mis++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, want);
      end
   endtask

   function automatic logic [31:0] addr_of(input int ch, input logic [1:0] r);
      logic [3:0] c;
      c = 4'(ch);
      return {BASE_PAGE, c, r, 2'b00};
   endfunction

   // Caller must be just after a clock edge; returns just after the acknowledging edge.
   task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                      input logic [31:0] wd, output logic [31:0] rdv);
      logic got;
      got = 1'b0;
      rdv = '0;
      iomem_valid = 1'b1;
      iomem_addr  = addr;
      iomem_wstrb = strb;
      iomem_wdata = wd;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk);
         #1;
         if (iomem_ready) begin
            got = 1'b1;
            rdv = iomem_rdata;
         end
      end
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      check("ack", {31'b0, got}, 32'h1);
   endtask

   task automatic rd(input int ch, input logic [1:0] r, output logic [31:0] v);
      bus(addr_of(ch, r), 4'h0, 32'h0, v);
   endtask

   task automatic wr(input int ch, input logic [1:0] r, input logic [31:0] d);
      logic [31:0] dummy;
      bus(addr_of(ch, r), 4'hF, d, dummy);
   endtask

   function automatic logic [1:0] nxt(input logic [1:0] s, input logic fwd);
      logic [1:0] r;
      case (s)
         2'b00:   r = fwd ? 2'b10 : 2'b01;
         2'b10:   r = fwd ? 2'b11 : 2'b00;
         2'b11:   r = fwd ? 2'b01 : 2'b10;
         default: r = fwd ? 2'b00 : 2'b11;
      endcase
      return r;
   endfunction

   task automatic steps(input int n, input logic fwd);
      for (int i = 0; i < n; i++) begin
         ab = nxt(ab, fwd);
         enc_a[0] = ab[1];
         enc_b[0] = ab[0];
         tick(10);
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick(2);
      resetn  = 1'b1;
      rst_cyc = cyc;
   endtask

   task automatic wait_to(input int k);
      if (cyc - rst_cyc < k) begin
         while (cyc - rst_cyc < k) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      resetn      = 1'b0;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      iomem_addr  = '0;
      iomem_wdata = '0;
      enc_a       = '0;
      enc_b       = '0;
      ab          = 2'b00;
      tick(3);
      resetn  = 1'b1;
      rst_cyc = cyc;

      check("rst_ready", {31'b0, iomem_ready}, 32'h0);
      check("rst_rdata", iomem_rdata, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      for (int ch = 0; ch < NUM_CH; ch++) begin
         rd(ch, R_CNT, rv);  check("rst_count", rv, 32'h0);
         rd(ch, R_VEL, rv);  check("rst_vel", rv, 32'h0);
         rd(ch, R_STAT, rv); check("rst_status", rv, 32'h0);
         rd(ch, R_CTRL, rv); check("rst_ctrl", rv, 32'h1);
      end

      seen = 1'b0;
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0300_0000;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         seen = seen | iomem_ready;
      end
      iomem_valid = 1'b0;
      check("nomatch_ready", {31'b0, seen}, 32'h0);

      steps(12, 1'b1);
      rd(0, R_CNT, rv); check("x4_fwd_ch0", rv, 32'd12);
      rd(1, R_CNT, rv); check("x4_fwd_ch1", rv, 32'd0);

      wr(0, R_CNT, 32'h0); wr(0, R_CTRL, 32'h5);
      steps(12, 1'b1);
      rd(0, R_CNT, rv); check("x2_fwd", rv, 32'd6);

      wr(0, R_CNT, 32'h0); wr(0, R_CTRL, 32'h9);
      steps(12, 1'b1);
      rd(0, R_CNT, rv); check("x1_fwd", rv, 32'd3);

      wr(0, R_CNT, 32'h0); wr(0, R_CTRL, 32'h3);
      steps(12, 1'b1);
      rd(0, R_CNT, rv); check("x4_inv", rv, 32'hFFFF_FFF4);

      wr(0, R_CTRL, 32'h1); wr(0, R_CNT, 32'h0); wr(0, R_STAT, 32'h7);
      steps(1, 1'b0);
      rd(0, R_CNT, rv);  check("underflow_count", rv, 32'hFFFF_FFFF);
      rd(0, R_STAT, rv); check("underflow_status", rv, 32'h2);
      check("irq_masked", {31'b0, irq}, 32'h0);
      wr(0, R_CTRL, 32'h11);
      tick(2);
      check("irq_set", {31'b0, irq}, 32'h1);
      wr(0, R_STAT, 32'h2);
      rd(0, R_STAT, rv); check("w1c_status", rv, 32'h0);
      tick(1);
      check("irq_clear", {31'b0, irq}, 32'h0);

      steps(1, 1'b1);
      rd(0, R_CNT, rv);  check("overflow_count", rv, 32'h0);
      rd(0, R_STAT, rv); check("overflow_status", rv, 32'h1);
      check("irq_ovf", {31'b0, irq}, 32'h1);
      wr(0, R_STAT, 32'h7); wr(0, R_CTRL, 32'h1);

      enc_a[0] = 1'b1; tick(2); enc_a[0] = 1'b0; tick(12);
      rd(0, R_CNT, rv); check("pulse2_count", rv, 32'h0);

      enc_a[0] = 1'b1; tick(3); enc_a[0] = 1'b0; tick(2);
      rd(0, R_CNT, rv); check("pulse3_t5", rv, 32'h0);
      tick(1);
      rd(0, R_CNT, rv); check("pulse3_t7", rv, 32'h1);
      tick(1);
      rd(0, R_CNT, rv); check("pulse3_t9", rv, 32'h0);

      tick(10);
      enc_a[0] = 1'b1; tick(3); enc_a[0] = 1'b0; tick(3);
      rd(0, R_CNT, rv); check("pulse3_t6", rv, 32'h1);
      tick(1);
      rd(0, R_CNT, rv); check("pulse3_t8", rv, 32'h1);
      tick(1);
      rd(0, R_CNT, rv); check("pulse3_t10", rv, 32'h0);

      tick(5);
      enc_a[0] = 1'b1; enc_b[0] = 1'b1; tick(12);
      rd(0, R_STAT, rv); check("qerr_status", rv, 32'h4);
      rd(0, R_CNT, rv);  check("qerr_count", rv, 32'h0);
      enc_a[0] = 1'b0; enc_b[0] = 1'b0; tick(12);
      wr(0, R_STAT, 32'h7);
      rd(0, R_STAT, rv); check("qerr_cleared", rv, 32'h0);

      ab = 2'b00;
      do_reset();
      wait_to(5);
      steps(5, 1'b1);
      wait_to(102);
      rd(0, R_VEL, rv); check("vel_win1", rv, 32'd5);
      wait_to(110);
      wr(0, R_CNT, 32'd1000);
      wait_to(115);
      steps(5, 1'b1);
      wait_to(205);
      rd(0, R_VEL, rv); check("vel_after_preset", rv, 32'd5);
      rd(0, R_CNT, rv); check("count_after_preset", rv, 32'd1005);

      wr(0, R_CNT, 32'h1234_5678);
      tick(2);
      ab = nxt(ab, 1'b1);
      enc_a[0] = ab[1];
      enc_b[0] = ab[0];
      tick(5);
      bus(addr_of(0, R_CNT), 4'h1, 32'h0000_00AB, rv);
      tick(10);
      rd(0, R_CNT, rv); check("strb_preset_wins", rv, 32'h1234_56AB);

      rd(5, R_CNT, rv); check("ch5_read_zero", rv, 32'h0);
      wr(5, R_CTRL, 32'h0);
      rd(1, R_CTRL, rv); check("ch5_write_ignored", rv, 32'h1);
      rd(0, R_CTRL, rv); check("ch0_ctrl_intact", rv, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/iomem_quad_encoder_bank.md
Name: iomem_quad_encoder_bank

Overview:
- Multi-channel quadrature encoder peripheral on the PicoSoC iomem bus. It replaces the per-encoder instances and their hand-written decode in the top level.
- Each channel does the following: synchronises and glitch-filters its A/B pins, decodes quadrature in a selectable x4/x2/x1 mode, and keeps a wrapping position counter with a presettable value.
- Each channel also measures velocity over a fixed sample window and flags sticky error/wrap status. All status flags combine into one interrupt line.

Parameters:
- NUM_CH, 2, number of encoder channels (1..16).
- CNT_W, 32, counter/velocity width in bits (8..32); register reads are zero-extended to 32 bits.
- FILT_LEN, 3, consecutive identical synchronised samples needed to accept a new pin level (1..15).
- VEL_PERIOD, 16000, velocity window in clk cycles (1 ms at 16 MHz); minimum 2.
- BASE_PAGE, 24'h030004, value of iomem_addr[31:8] that selects this block.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- iomem_valid  in  1  bus request
- iomem_ready  out  1  one-cycle acknowledge
- iomem_wstrb  in  4  byte write strobes; 0 = read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid when iomem_ready=1
- enc_a  in  NUM_CH  encoder phase A pins, asynchronous
- enc_b  in  NUM_CH  encoder phase B pins, asynchronous
- irq  out  1  level interrupt

Behaviour:
- Reset: all outputs reset to 0 (iomem_ready, iomem_rdata, irq); COUNT, VELOCITY, STATUS, snapshot and prescaler reset to 0; CTRL resets to 0x1; filter and sync state reset to 0.
- Address map: register offset = iomem_addr[7:0]; channel = offset[7:4]; register = offset[3:2].
  - 0 COUNT: RW; a write presets the counter.
  - 1 VELOCITY: RO, signed.
  - 2 STATUS: W1C; bit0 overflow, bit1 underflow, bit2 quadrature error.
  - 3 CTRL: RW.
    - bit0 enable.
    - bit1 invert direction.
    - bits[3:2] mode: 00 x4, 01 x2, 10 x1, 11 treated as x4.
    - bit4 irq enable.
  - Channel index >= NUM_CH: reads 0, writes ignored, still acknowledged.
- Handshake:
  - When iomem_valid && !iomem_ready && page match, iomem_ready=1 for exactly the next cycle, with iomem_rdata registered in the same cycle.
  - Back-to-back requests are acknowledged every second cycle.
  - With no match, iomem_ready stays 0 and iomem_rdata holds its value.
  - Byte strobes apply per byte to COUNT, CTRL and STATUS; bits above CNT_W are ignored.
- Input path:
  - 2-FF synchroniser, then filter: the filtered level changes only after FILT_LEN consecutive equal samples that differ from the current filtered level.
  - Pin change to COUNT update latency = FILT_LEN+3 cycles.
- Decode: prev and current filtered {A,B} per cycle.
  - Forward sequence is 00→10→11→01→00; each step is +1, and the reverse steps are −1. CTRL.bit1 negates direction.
  - x4: every valid step counts.
  - x2: only steps where A changes count.
  - x1: only steps where A rises count.
  - Both A and B changing in one cycle: no count; STATUS.bit2 set.
  - When CTRL.enable=0, decode is suppressed but the filter keeps running.
- Counter:
  - Wraps modulo 2^CNT_W.
  - +1 from all-ones sets overflow; −1 from 0 sets underflow.
  - COUNT write in the same cycle as a count event: the written value wins and the event is dropped.
- Velocity:
  - A global prescaler counts 0..VEL_PERIOD-1.
  - At the terminal cycle, for every channel: VELOCITY <= COUNT − snapshot (CNT_W-bit wrap arithmetic) and snapshot <= COUNT.
  - A COUNT preset also loads snapshot with the preset value, so presets do not appear as velocity.
- STATUS:
  - Sticky. W1C clears the selected bits.
  - A set event in the same cycle as a clear leaves the bit set.
- irq: registered OR over channels of (|STATUS && CTRL.bit4); 1-cycle latency after the status change.
- Reset asserted mid-transaction: iomem_ready drops the next cycle and the transaction is lost; the master retries.

Decomposition:
- Package iomem_quad_encoder_pkg:
  - Register offset constants (REG_COUNT, REG_VELOCITY, REG_STATUS, REG_CTRL).
  - Mode encodings (MODE_X4, MODE_X2, MODE_X1).
  - STATUS and CTRL bit indices.
- Sub-module quad_encoder_channel holds the synchroniser, filter, decoder, counter, snapshot/velocity, STATUS and CTRL registers. It is instantiated NUM_CH times via generate.
- The top level holds only bus decode, readback mux, prescaler and irq.

Test Plan:
- Reset sequence → every channel reads COUNT=0, VELOCITY=0, STATUS=0, CTRL=0x1; irq=0; an unmatched address (page 0x030000) never raises iomem_ready.
- x4 mode, ch0, 3 full forward cycles (12 steps), steps 10 cycles apart → ch0 COUNT=12 and ch1 COUNT=0. Repeat in x2 mode → 6; in x1 mode → 3. With CTRL.bit1=1 in x4 mode → 0xFFFFFFF4.
- From COUNT=0, one reverse step → COUNT=0xFFFFFFFF, STATUS=0x2. Then enable irq → irq=1. Write STATUS=0x2 → STATUS=0, irq=0.
- FILT_LEN=3: A pulse of 2 cycles → COUNT unchanged. A pulse of 3 cycles → two steps, net 0, each visible 6 cycles after its edge. A and B toggled in the same cycle → STATUS.bit2=1, COUNT unchanged.
- VEL_PERIOD=100: 5 forward steps per window → VELOCITY=5. Write COUNT=1000 mid-window → VELOCITY stays 5 next window and COUNT=1005.
- COUNT write with wstrb=0x1 and data 0xAB, coinciding with a filtered step → COUNT low byte=0xAB, upper bytes preserved, step dropped. Read of channel 5 with NUM_CH=2 → acknowledged with rdata=0.
